// File: rtl/gfx_pkg.sv
// gfx_pkg: shared framebuffer types and constants for the pixel z-buffer.
//   pixel_t    - packed incoming pixel {x, y, z, color}
//   zb_state_e - clear controller states
//   fb_addr()  - framebuffer address {y, x} of a pixel
package gfx_pkg;

  localparam int unsigned FB_ADDR_W = 12;
  localparam int unsigned Z_W       = 6;
  localparam int unsigned COLOR_W   = 10;
  localparam int unsigned FB_DEPTH  = 1 << FB_ADDR_W;
  localparam logic [Z_W-1:0] Z_FAR  = 6'h3F;

  typedef struct packed {
    logic [5:0]         x;
    logic [5:0]         y;
    logic [Z_W-1:0]     z;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } zb_state_e;

  function automatic logic [FB_ADDR_W-1:0] fb_addr(input pixel_t p);
    return {p.y, p.x};
  endfunction

endpackage

// File: rtl/zbuf_sdp_ram.sv
// zbuf_sdp_ram: simple dual-port RAM, one write port, one read port with
// a registered read. A read and a write of the same address in one cycle
// return the old data.
//   clk, rst  - clock; rst clears only the read data register
//   we_i, waddr_i, wdata_i - write port
//   raddr_i, rdata_o       - read port, data valid one cycle after raddr_i
module zbuf_sdp_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_zbuffer.sv
// pixel_zbuffer: 64x64 framebuffer with optional depth test and a
// frame-start clear engine.
//   clk, rst     - clock, synchronous active-high reset
//   pixel_valid, pixel_in - incoming pixel stream {x, y, z, color}, no backpressure
//   frame_start  - starts (or restarts) a full-buffer clear
//   busy         - high while clearing
//   clear_done   - one-cycle pulse when a clear pass completes
//   rd_addr, rd_color - display read port {y, x}, one cycle latency
//   drop_count   - saturating count of pixels dropped during clear
// Build option: define ZBUF_DEPTH_TEST_EN to compile in the z RAM, depth
// compare and depth forwarding; otherwise pixels are drawn in arrival order.
module pixel_zbuffer
  import gfx_pkg::*;
#(
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = 10'h000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pixel_valid,
  input  logic [27:0]          pixel_in,
  input  logic                 frame_start,
  output logic                 busy,
  output logic                 clear_done,
  input  logic [FB_ADDR_W-1:0] rd_addr,
  output logic [COLOR_W-1:0]   rd_color,
  output logic [15:0]          drop_count
);

  zb_state_e            state_q, state_d;
  logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d, clr_waddr;
  logic                 clear_done_q, clear_done_d;
  logic [15:0]          drop_count_q;

  pixel_t pix;
  logic   accept, drop, kill, pass;

  logic                 s1_valid_q, s2_valid_q;
  logic [FB_ADDR_W-1:0] s1_addr_q, s2_addr_q;
  logic [COLOR_W-1:0]   s1_color_q, s2_color_q;

  logic                 ram_we;
  logic [FB_ADDR_W-1:0] ram_waddr;
  logic [COLOR_W-1:0]   color_wdata;

  assign pix    = pixel_t'(pixel_in);
  assign accept = pixel_valid && (state_q == IDLE) && !frame_start;
  assign drop   = pixel_valid && !accept;
  // Anything still in the pipe when a clear starts must never reach the RAMs.
  assign kill   = frame_start || (state_q == CLEAR);

  // A restart writes address 0 in the same cycle frame_start is seen.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clear_done_d = 1'b0;
    clr_waddr    = frame_start ? '0 : clr_addr_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_waddr + 1'b1;
        if (!frame_start && (clr_waddr == '1)) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      clear_done_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clear_done_q <= clear_done_d;
      if (drop && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q && pass && !kill;
    end
  end

  always_ff @(posedge clk) begin
    s1_addr_q  <= fb_addr(pix);
    s1_color_q <= pix.color;
    s2_addr_q  <= s1_addr_q;
    s2_color_q <= s1_color_q;
  end

  // Clear owns the write port; pixel writes only happen in IDLE.
  always_comb begin
    ram_we      = s2_valid_q;
    ram_waddr   = s2_addr_q;
    color_wdata = s2_color_q;
    if (state_q == CLEAR) begin
      ram_we      = 1'b1;
      ram_waddr   = clr_waddr;
      color_wdata = CLEAR_COLOR;
    end
  end

`ifdef ZBUF_DEPTH_TEST_EN
  logic                 s3_valid_q;
  logic [FB_ADDR_W-1:0] s3_addr_q;
  logic [Z_W-1:0]       s1_z_q, s2_z_q, s3_z_q;
  logic [Z_W-1:0]       z_rdata, z_stored, z_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
    end else begin
      s3_valid_q <= s2_valid_q && !kill;
    end
  end

  always_ff @(posedge clk) begin
    s1_z_q    <= pix.z;
    s2_z_q    <= s1_z_q;
    s3_addr_q <= s2_addr_q;
    s3_z_q    <= s2_z_q;
  end

  // The RAM read missed the writes of the previous two cycles: s3 was
  // written at the edge that captured the read, s2 is being written now.
  always_comb begin
    z_stored = z_rdata;
    if (s3_valid_q && (s3_addr_q == s1_addr_q)) begin
      z_stored = s3_z_q;
    end
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      z_stored = s2_z_q;
    end
  end

  assign pass    = (s1_z_q <= z_stored);
  assign z_wdata = (state_q == CLEAR) ? Z_FAR : s2_z_q;

  zbuf_sdp_ram #(
    .WIDTH (Z_W),
    .DEPTH (FB_DEPTH)
  ) u_z_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (z_wdata),
    .raddr_i (fb_addr(pix)),
    .rdata_o (z_rdata)
  );
`else
  logic unused_z;
  assign unused_z = ^pix.z;
  assign pass     = 1'b1;
`endif

  zbuf_sdp_ram #(
    .WIDTH (COLOR_W),
    .DEPTH (FB_DEPTH)
  ) u_color_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (color_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_color)
  );

  assign busy       = (state_q == CLEAR);
  assign clear_done = clear_done_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pixel_zbuffer.sv
// tb_pixel_zbuffer: directed, table-driven self-checking bench for
// pixel_zbuffer. Expected colors depend on ZBUF_DEPTH_TEST_EN.
module tb_pixel_zbuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_valid;
  logic [27:0] pixel_in;
  logic        frame_start;
  logic        busy;
  logic        clear_done;
  logic [11:0] rd_addr;
  logic [9:0]  rd_color;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  pixel_zbuffer #(
    .CLEAR_COLOR (10'h000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .frame_start (frame_start),
    .busy        (busy),
    .clear_done  (clear_done),
    .rd_addr     (rd_addr),
    .rd_color    (rd_color),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic [5:0] z;
    logic [9:0] color;
    bit         chk;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input int x, input int y, input int z, input int c,
                              input bit chk, input int exp_dt, input int exp_po);
    vec_t v;
    v.x     = 6'(x);
    v.y     = 6'(y);
    v.z     = 6'(z);
    v.color = 10'(c);
    v.chk   = chk;
`ifdef ZBUF_DEPTH_TEST_EN
    v.exp   = 10'(exp_dt);
`else
    v.exp   = 10'(exp_po);
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [9:0] c);
    rd_addr = a;
    tick();
    c = rd_color;
  endtask

  // Pulses frame_start, then watches busy/clear_done for n cycles.
  // Sample i is taken while the clear engine is on address i of its pass.
  task automatic run_clear(input bit restart, input bit with_drops, input int n,
                           output int busy_cnt, output int done_cnt, output int done_idx);
    busy_cnt    = 0;
    done_cnt    = 0;
    done_idx    = -1;
    frame_start = 1'b1;
    pixel_valid = with_drops;
    pixel_in    = {6'd4, 6'd0, 6'd1, 10'h3C3};
    tick();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (busy) busy_cnt++;
      if (clear_done) begin
        done_cnt++;
        done_idx = i;
      end
      frame_start = restart && (i == 2000);
      pixel_valid = with_drops && (i >= 4000) && (i < 4003);
      pixel_in    = {6'(i - 3999), 6'd0, 6'd1, 10'h3C3};
      tick();
    end
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  initial begin
    int         bc, dc, di, bad;
    logic [9:0] c;

    vecs[0]  = mk( 5,  3, 20, 'h155, 0, 'h000, 'h000);
    vecs[1]  = mk( 5,  3, 30, 'h0AA, 1, 'h155, 'h0AA);
    vecs[2]  = mk(10, 10, 40, 'h001, 0, 'h000, 'h000);
    vecs[3]  = mk(10, 10, 10, 'h002, 0, 'h000, 'h000);
    vecs[4]  = mk(10, 10, 25, 'h003, 1, 'h002, 'h003);
    vecs[5]  = mk(20,  1, 10, 'h0F0, 0, 'h000, 'h000);
    vecs[6]  = mk(20,  1, 10, 'h0F1, 1, 'h0F1, 'h0F1);
    vecs[7]  = mk( 7,  7, 10, 'h111, 0, 'h000, 'h000);
    vecs[8]  = mk( 7,  7, 50, 'h222, 1, 'h111, 'h222);
    vecs[9]  = mk( 1,  2, 30, 'h010, 0, 'h000, 'h000);
    vecs[10] = mk( 2,  2,  5, 'h030, 1, 'h030, 'h030);
    vecs[11] = mk( 1,  2, 40, 'h020, 1, 'h010, 'h020);
    vecs[12] = mk(63, 63, 63, 'h3FF, 1, 'h3FF, 'h3FF);
    vecs[13] = mk( 0,  0,  0, 'h2AB, 1, 'h2AB, 'h2AB);

    rst         = 1'b1;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    frame_start = 1'b0;
    rd_addr     = '0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_clear_done", int'(clear_done), 0);
    check("rst_drop_count", int'(drop_count), 0);
    check("rst_rd_color", int'(rd_color), 0);
    rst = 1'b0;
    tick();

    // Full clear with one coincident and three mid-clear pixels dropped.
    run_clear(1'b0, 1'b1, 4200, bc, dc, di);
    check("clear_busy_cycles", bc, 4096);
    check("clear_done_pulses", dc, 1);
    check("clear_done_cycle", di, 4096);
    check("clear_drop_count", int'(drop_count), 4);

    bad = 0;
    for (int a = 0; a < 4096; a++) begin
      rd(12'(a), c);
      if (c !== 10'h000) bad++;
    end
    check("clear_readback_bad", bad, 0);

    // Back-to-back pixel stream, then read back final colors.
    for (int i = 0; i < 14; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = {vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].color};
      tick();
    end
    pixel_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].chk) begin
        rd({vecs[i].y, vecs[i].x}, c);
        check($sformatf("vec%0d_color", i), int'(c), int'(vecs[i].exp));
      end
    end

    // Write lands two cycles after acceptance; same-cycle read sees old data.
    rd_addr     = 12'h300;
    pixel_valid = 1'b1;
    pixel_in    = {6'd0, 6'd12, 6'd9, 10'h155};
    tick();
    pixel_valid = 1'b0;
    tick();
    tick();
    check("wr_rd_same_cycle_old", int'(rd_color), 'h000);
    tick();
    check("wr_rd_next_cycle_new", int'(rd_color), 'h155);

    // Restart at clear address 2000.
    run_clear(1'b1, 1'b0, 6200, bc, dc, di);
    check("restart_busy_cycles", bc, 6096);
    check("restart_done_pulses", dc, 1);
    check("restart_done_cycle", di, 6096);
    check("restart_drop_count", int'(drop_count), 4);
    rd(12'h0C5, c);
    check("restart_rd_0C5", int'(c), 0);
    rd(12'hFFF, c);
    check("restart_rd_FFF", int'(c), 0);
    rd(12'h300, c);
    check("restart_rd_300", int'(c), 0);

    // Reset in the middle of a clear abandons it.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_drop_count", int'(drop_count), 0);
    bc = 0;
    dc = 0;
    for (int i = 0; i < 4200; i++) begin
      if (busy) bc++;
      if (clear_done) dc++;
      tick();
    end
    check("midrst_busy_after", bc, 0);
    check("midrst_no_done", dc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_zbuffer.md
PIXEL_ZBUFFER -- requirements
Module: pixel_zbuffer

Interface
REQ-001 SHALL have parameter: CLEAR_COLOR, 10'h000, color written to every location during clear.
REQ-002 SHALL have port: clk  in  1  clock; all logic on posedge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: pixel_valid  in  1  pixel_in qualifier; no backpressure, one pixel per cycle possible.
REQ-005 SHALL have port: pixel_in  in  28  {x[27:22], y[21:16], z[15:10], color[9:0]}; x,y unsigned 0..63.
REQ-006 SHALL have port: frame_start  in  1  single-cycle pulse requesting buffer clear.
REQ-007 SHALL have port: busy  out  1  high while clearing.
REQ-008 SHALL have port: clear_done  out  1  one-cycle pulse when clear completes.
REQ-009 SHALL have port: rd_addr  in  12  display read address {y,x}.
REQ-010 SHALL have port: rd_color  out  10  color at rd_addr, registered.
REQ-011 SHALL have port: drop_count  out  16  pixels discarded during clear, saturating at 16'hFFFF.

Function
REQ-012 SHALL hold 4096-entry z RAM (6 b) and color RAM (10 b), address {y,x}.
REQ-013 SHALL be FSM with states IDLE and CLEAR; rst -> IDLE.
REQ-014 IDLE -> CLEAR on frame_start; CLEAR writes z=6'h3F, color=CLEAR_COLOR at address 0..4095, one per cycle, ascending.
REQ-015 CLEAR -> IDLE the cycle after address 4095 written; clear_done pulses that cycle; busy high exactly 4096 cycles.
REQ-016 frame_start during CLEAR SHALL restart address at 0; no clear_done for the aborted pass.
REQ-017 pixel_valid during CLEAR or coincident with frame_start SHALL drop the pixel and increment drop_count.
REQ-018 In IDLE, accepted pixel at cycle N SHALL read z RAM at N, compare at N+1, write both RAMs at N+2 if passed.
REQ-019 Depth test SHALL pass when z_new <= z_stored (unsigned; smaller nearer; ties: later pixel wins).
REQ-020 Compare SHALL use forwarded depth when a write to same address is pending at N+1 or N+2, so back-to-back same-address pixels resolve as if sequential.
REQ-021 Pixels in flight when CLEAR begins SHALL be discarded (no writes after first clear write).
REQ-022 rd_color SHALL present color RAM at rd_addr one cycle later; same-cycle write/read of one address returns old data.
REQ-023 drop_count SHALL clear to 0 only on rst.

Reset
REQ-024 On rst: FSM IDLE, busy=0, clear_done=0, drop_count=0, pipeline valids=0, rd_color=0.
REQ-025 rst SHALL NOT initialise RAM contents; rst mid-clear abandons clear, no clear_done.

Configuration
REQ-026 Macro ZBUF_DEPTH_TEST_EN defined: depth test per REQ-019/020 compiled in.
REQ-027 Macro undefined: z RAM, compare and forwarding omitted; every IDLE pixel writes color at N+2 (painter's order); clear writes color only.

Structure
REQ-028 Package gfx_pkg SHALL hold pixel_t packed struct (x,y,z,color), FB_ADDR_W=12, Z_W=6, COLOR_W=10, Z_FAR=6'h3F.
REQ-029 Sub-module zbuf_sdp_ram (parameterised width/depth, simple dual-port, 1-cycle registered read) SHALL be instantiated for z and color RAMs.

Verification
REQ-030 frame_start, then 4096 cycles -> busy high 4096 cycles, clear_done one pulse; reading all addresses returns 10'h000.
REQ-031 After clear, pixel x=5,y=3,z=20,color=0x155 then x=5,y=3,z=30,color=0x0AA -> rd_addr 12'h0C5 returns 0x155.
REQ-032 Back-to-back same address z=40 color 0x001, z=10 color 0x002, z=25 color 0x003 -> final 0x002 (forwarding); z=10 tie later -> replaces.
REQ-033 Three pixels during CLEAR plus one coincident with frame_start -> drop_count=4, no RAM write.
REQ-034 frame_start at clear address 2000 -> restart, busy total 2000+4096 cycles, one clear_done.
REQ-035 Without ZBUF_DEPTH_TEST_EN: z=10 then z=50 same address -> second color stored.
